ddr_cmd_scheduler: RTL and testbench

DDR_CMD_SCHEDULER -- requirements
Module: ddr_cmd_scheduler

---
 rtl/ddr_cmd_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_scheduler.sv
// rtl/ddr_cmd_scheduler.sv - round-robin read-request scheduler feeding a datamover MM2S command port
//
// Purpose:
//   Arbitrates NUM_REQ read requesters onto one datamover command stream.
//   Each accepted request is split into commands of at most CHUNK bytes.
//   No more than MAX_OUT commands may be outstanding at once. A route FIFO
//   holds the requester id of every outstanding command, so the MM2S data
//   stream can be steered back to its owner.
//
// Ports:
//   clk         core clock; all logic on its rising edge
//   rst         asynchronous active-low reset
//   req_valid   per-requester request valid
//   req_ready   per-requester accept strobe, one-hot or zero
//   req_addr    packed 32-bit byte start addresses, requester i at [32i+31:32i]
//   req_size    packed 32-bit byte counts, same packing
//   cmd_tdata   72-bit datamover command word
//   cmd_tvalid  command valid
//   cmd_tready  command ready
//   mon_tvalid  tap of the MM2S data stream tvalid
//   mon_tready  tap of the MM2S data stream tready
//   mon_tlast   tap of the MM2S data stream tlast
//   route_id    owner of the data currently streaming
//   route_valid route_id meaningful (at least one command outstanding)
//   busy        issuing commands or commands still outstanding

module ddr_cmd_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int CHUNK   = 4096,
  parameter int MAX_OUT = 4,
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_size,
  output logic [71:0]          cmd_tdata,
  output logic                 cmd_tvalid,
  input  logic                 cmd_tready,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  output logic [IW-1:0]        route_id,
  output logic                 route_valid,
  output logic                 busy
);

  localparam int PW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW    = $clog2(MAX_OUT) + 1;
  localparam int DEPTH = 1 << PW;
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [31:0]   CHUNK_C   = 32'(CHUNK);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_id;
  logic [31:0]     r_addr;
  logic [31:0]     r_rem;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [IW-1:0]   r_fifo [DEPTH];

  logic [IW-1:0]   w_win;
  logic            w_win_vld;
  logic [IW-1:0]   w_rr_nxt;
  logic            w_grant;
  logic [31:0]     w_gr_addr;
  logic [31:0]     w_gr_size;
  logic [31:0]     w_chunk;
  logic            w_last_chunk;
  logic            w_cmd_hs;
  logic            w_push;
  logic            w_pop;

  // Round-robin search: scan from r_rr_ptr upward with wrap. Walking the
  // offsets from highest to lowest and overwriting leaves the closest
  // valid requester as the winner.
  always_comb begin
    int            idx;
    logic [IW-1:0] sel;
    idx       = 0;
    sel       = '0;
    w_win     = '0;
    w_win_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      sel = IW'(idx);
      if (req_valid[sel]) begin
        w_win     = sel;
        w_win_vld = 1'b1;
      end
    end
  end

  assign w_rr_nxt  = (w_win == LAST_IDX) ? '0 : w_win + IW'(1);
  assign w_gr_addr = req_addr[{w_win, 5'd0} +: 32];
  assign w_gr_size = req_size[{w_win, 5'd0} +: 32];

  // Grants only in IDLE. The rst term keeps req_ready low while reset is
  // held, even though req_ready is combinational from req_valid.
  assign w_grant = rst && (r_state == ST_IDLE) && w_win_vld;

  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_win] = 1'b1;
    end
  end

  assign w_chunk      = (r_rem < CHUNK_C) ? r_rem : CHUNK_C;
  assign w_last_chunk = (r_rem == w_chunk);

  // The command word is built only from registers. It therefore holds
  // steady under back-pressure, and it is forced to zero when not valid.
  assign cmd_tvalid = (r_state == ST_ISSUE) && (r_count < MAX_OUT_C);
  assign cmd_tdata  = cmd_tvalid ?
                      {8'h00, r_addr, 1'b0, 1'b1, 2'b00, 4'(r_id), 1'b1, w_chunk[22:0]} :
                      72'd0;

  assign w_cmd_hs = cmd_tvalid && cmd_tready;
  assign w_push   = w_cmd_hs;
  // A final beat with nothing outstanding is stray and must not underflow.
  assign w_pop    = mon_tvalid && mon_tready && mon_tlast && (r_count != '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant && (w_gr_size != 32'd0)) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_cmd_hs && w_last_chunk) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_addr   <= '0;
      r_rem    <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= w_rr_nxt;
      r_id     <= w_win;
      r_addr   <= w_gr_addr;
      r_rem    <= w_gr_size;
    end else if (w_cmd_hs) begin
      r_addr   <= r_addr + w_chunk;
      r_rem    <= r_rem - w_chunk;
    end
  end

  // Route FIFO pointers and occupancy. cmd_tvalid is low when the FIFO is
  // full, so a push can never overflow it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset: entries are only read while r_count != 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= r_id;
    end
  end

  assign route_valid = (r_count != '0);
  assign route_id    = route_valid ? r_fifo[r_rd_ptr] : '0;
  assign busy        = (r_state != ST_IDLE) || route_valid;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// tb/tb_ddr_cmd_scheduler.sv - self-checking bench for ddr_cmd_scheduler
module tb_ddr_cmd_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_size;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        mon_tlast;
  logic [0:0]  route_id;
  logic        route_valid;
  logic        busy;

  int tests;
  int fails;

  ddr_cmd_scheduler #(.NUM_REQ(2), .CHUNK(4096), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .route_id(route_id), .route_valid(route_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Command word assembled field by field from the datamover layout.
  function automatic logic [71:0] exp_word(input logic [31:0] a, input logic [31:0] n, input int id);
    logic [71:0] w;
    w         = '0;
    w[22:0]   = n[22:0];
    w[23]     = 1'b1;
    w[27:24]  = id[3:0];
    w[30]     = 1'b1;
    w[63:32]  = a;
    return w;
  endfunction

  task automatic idle_inputs();
    req_valid  = '0;
    req_addr   = '0;
    req_size   = '0;
    cmd_tready = 1'b0;
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst        = 1'b0;
    req_valid  = 2'b11;
    req_size   = {32'd64, 32'd64};
    cmd_tready = 1'b1;
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    tests++; if (cmd_tvalid !== 1'b0) begin fails++; $display("FAIL reset_cmd_tvalid: got %b expected 0", cmd_tvalid); end
    tests++; if (cmd_tdata !== 72'd0) begin fails++; $display("FAIL reset_cmd_tdata: got %h expected 0", cmd_tdata); end
    tests++; if (route_valid !== 1'b0) begin fails++; $display("FAIL reset_route_valid: got %b expected 0", route_valid); end
    tests++; if (route_id !== 1'b0) begin fails++; $display("FAIL reset_route_id: got %b expected 0", route_id); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_chunks();
    logic [71:0] exp [3];
    int n;
    int beats;
    exp[0] = exp_word(32'h1000, 32'd4096, 0);
    exp[1] = exp_word(32'h2000, 32'd4096, 0);
    exp[2] = exp_word(32'h3000, 32'd1808, 0);
    n = 0;
    beats = 0;
    do_reset();
    @(negedge clk);
    req_valid       = 2'b01;
    req_addr[31:0]  = 32'h1000;
    req_size[31:0]  = 32'd10000;
    cmd_tready      = 1'b1;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL chunks_grant: got %b expected 01", req_ready); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (c == 0) begin
        tests++; if (cmd_tvalid !== 1'b1) begin fails++; $display("FAIL chunks_latency: got %b expected 1", cmd_tvalid); end
      end
      if (cmd_tvalid === 1'b1) begin
        if (n < 3) begin
          tests++; if (cmd_tdata !== exp[n]) begin fails++; $display("FAIL chunks_word%0d: got %h expected %h", n, cmd_tdata, exp[n]); end
        end
        n++;
      end
    end
    tests++; if (n != 3) begin fails++; $display("FAIL chunks_count: got %0d expected 3", n); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
      #1;
      if (route_valid === 1'b1) begin
        tests++; if (route_id !== 1'b0) begin fails++; $display("FAIL chunks_route_id: got %b expected 0", route_id); end
        beats++;
      end
    end
    tests++; if (beats != 3) begin fails++; $display("FAIL chunks_beats: got %0d expected 3", beats); end
    @(negedge clk);
    idle_inputs();
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL chunks_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int grants [$];
    do_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      req_valid  = 2'b11;
      req_addr   = {32'h0002_0000, 32'h0001_0000};
      req_size   = {32'd32, 32'd32};
      cmd_tready = 1'b1;
      mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
      #1;
      if (req_ready !== 2'b00 && grants.size() < 4) begin
        tests++; if ($countones(req_ready) != 1) begin fails++; $display("FAIL rr_onehot: got %b expected one-hot", req_ready); end
        grants.push_back(req_ready[1] ? 1 : 0);
      end
    end
    idle_inputs();
    tests++;
    if (grants.size() != 4) begin
      fails++; $display("FAIL rr_grant_count: got %0d expected 4", grants.size());
    end else if (grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
      fails++; $display("FAIL rr_order: got %0d%0d%0d%0d expected 0101", grants[0], grants[1], grants[2], grants[3]);
    end
  endtask

  task automatic test_max_out();
    int n;
    n = 0;
    do_reset();
    @(negedge clk);
    req_valid      = 2'b01;
    req_addr[31:0] = 32'h0;
    req_size[31:0] = 32'd32768;
    cmd_tready     = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (cmd_tvalid === 1'b1) n++;
    end
    tests++; if (n != 4) begin fails++; $display("FAIL maxout_first: got %0d expected 4", n); end
    tests++; if (cmd_tvalid !== 1'b0) begin fails++; $display("FAIL maxout_stall: got %b expected 0", cmd_tvalid); end
    @(negedge clk);
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
    #1;
    if (cmd_tvalid === 1'b1) n++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
      #1;
      if (cmd_tvalid === 1'b1) n++;
    end
    tests++; if (n != 5) begin fails++; $display("FAIL maxout_one_more: got %0d expected 5", n); end
    do_reset();
  endtask

  task automatic test_zero_size();
    int pulses;
    int cv_seen;
    int busy_seen;
    pulses = 0; cv_seen = 0; busy_seen = 0;
    do_reset();
    @(negedge clk);
    req_valid       = 2'b10;
    req_addr[63:32] = 32'h4000;
    req_size[63:32] = 32'd0;
    cmd_tready      = 1'b1;
    #1;
    if (req_ready[1] === 1'b1) pulses++;
    if (busy === 1'b1) busy_seen++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (req_ready[1] === 1'b1) pulses++;
      if (cmd_tvalid === 1'b1) cv_seen++;
      if (busy === 1'b1) busy_seen++;
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL zero_pulses: got %0d expected 1", pulses); end
    tests++; if (cv_seen != 0) begin fails++; $display("FAIL zero_cmd_tvalid: got %0d cycles expected 0", cv_seen); end
    tests++; if (busy_seen != 0) begin fails++; $display("FAIL zero_busy: got %0d cycles expected 0", busy_seen); end
    @(negedge clk);
    req_valid = 2'b11;
    req_size  = '0;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL zero_next_rr: got %b expected 01", req_ready); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [71:0] held;
    int n;
    int beats;
    n = 0; beats = 0;
    do_reset();
    @(negedge clk);
    req_valid       = 2'b10;
    req_addr[63:32] = 32'h0000_8000;
    req_size[63:32] = 32'd12388;
    cmd_tready      = 1'b1;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_grant: got %b expected 10", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    cmd_tready = 1'b0;
    #1;
    held = cmd_tdata;
    tests++; if (held !== exp_word(32'h9000, 32'd4096, 1)) begin fails++; $display("FAIL bp_second_word: got %h expected %h", held, exp_word(32'h9000, 32'd4096, 1)); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      tests++; if (cmd_tvalid !== 1'b1 || cmd_tdata !== held) begin fails++; $display("FAIL bp_stable: got %b/%h expected 1/%h", cmd_tvalid, cmd_tdata, held); end
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      cmd_tready = 1'b1;
      #1;
      if (cmd_tvalid === 1'b1) n++;
    end
    tests++; if (n != 3) begin fails++; $display("FAIL bp_remaining: got %0d expected 3", n); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
      #1;
      if (route_valid === 1'b1) begin
        tests++; if (route_id !== 1'b1) begin fails++; $display("FAIL bp_route_id: got %b expected 1", route_id); end
        beats++;
      end
    end
    tests++; if (beats != 4) begin fails++; $display("FAIL bp_beats: got %0d expected 4", beats); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    do_reset();
    @(negedge clk);
    req_valid      = 2'b01;
    req_addr[31:0] = 32'h1000;
    req_size[31:0] = 32'd10000;
    cmd_tready     = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = '0;
    #1;
    tests++; if (cmd_tvalid !== 1'b1 || cmd_tdata !== exp_word(32'h3000, 32'd1808, 0)) begin fails++; $display("FAIL mid_third_chunk: got %b/%h expected 1/%h", cmd_tvalid, cmd_tdata, exp_word(32'h3000, 32'd1808, 0)); end
    rst       = 1'b0;
    req_valid = 2'b11;
    #1;
    tests++; if (cmd_tvalid !== 1'b0 || cmd_tdata !== 72'd0) begin fails++; $display("FAIL mid_cmd_cleared: got %b/%h expected 0/0", cmd_tvalid, cmd_tdata); end
    tests++; if (route_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin fails++; $display("FAIL mid_outputs: got rv=%b busy=%b ready=%b expected 0/0/00", route_valid, busy, req_ready); end
    @(negedge clk);
    idle_inputs();
    cmd_tready = 1'b1;
    rst        = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (cmd_tvalid === 1'b1 || busy === 1'b1 || route_valid === 1'b1) stray++;
    end
    tests++; if (stray != 0) begin fails++; $display("FAIL mid_residual: got %0d active cycles expected 0", stray); end
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL mid_first_grant: got %b expected 01", req_ready); end
    @(negedge clk);
    idle_inputs();
  endtask

  // Reference model: a queue of pending command words, a queue of issued
  // ids awaiting their final beat, and the last-granted index.
  task automatic test_random();
    logic [71:0] m_cmds [$];
    int          m_route [$];
    int          m_rr;
    bit          m_issue;
    logic [1:0]  rv;
    logic [31:0] a [2];
    logic [31:0] s [2];
    logic [1:0]  exp_ready;
    int          win;
    bit          exp_cv;
    bit          beat;
    m_rr = 0;
    m_issue = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        rv[i] = ($urandom_range(0, 3) == 0);
        a[i]  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_E000 + 32'($urandom_range(0, 8191))) : 32'($urandom);
        case ($urandom_range(0, 5))
          0:       s[i] = 32'd0;
          1:       s[i] = 32'd4096 * 32'($urandom_range(1, 3));
          2:       s[i] = 32'($urandom_range(1, 31));
          default: s[i] = 32'($urandom_range(1, 20000));
        endcase
        req_addr[32*i +: 32] = a[i];
        req_size[32*i +: 32] = s[i];
      end
      req_valid  = rv;
      cmd_tready = ($urandom_range(0, 3) != 0);
      mon_tvalid = ($urandom_range(0, 1) == 1);
      mon_tready = ($urandom_range(0, 3) != 0);
      mon_tlast  = ($urandom_range(0, 2) == 0);
      #1;
      exp_ready = 2'b00;
      win = -1;
      if (!m_issue) begin
        for (int k = 0; k < 2; k++) begin
          if (win < 0 && rv[(m_rr + k) % 2]) win = (m_rr + k) % 2;
        end
        if (win >= 0) exp_ready[win] = 1'b1;
      end
      exp_cv = m_issue && (m_route.size() < 4);
      tests++; if (req_ready !== exp_ready) begin fails++; $display("FAIL rnd_req_ready c=%0d: got %b expected %b", c, req_ready, exp_ready); end
      tests++; if (cmd_tvalid !== exp_cv) begin fails++; $display("FAIL rnd_cmd_tvalid c=%0d: got %b expected %b", c, cmd_tvalid, exp_cv); end
      if (exp_cv) begin
        tests++; if (cmd_tdata !== m_cmds[0]) begin fails++; $display("FAIL rnd_cmd_tdata c=%0d: got %h expected %h", c, cmd_tdata, m_cmds[0]); end
      end
      tests++; if (route_valid !== (m_route.size() != 0)) begin fails++; $display("FAIL rnd_route_valid c=%0d: got %b expected %b", c, route_valid, m_route.size() != 0); end
      if (m_route.size() != 0) begin
        tests++; if (int'(route_id) != m_route[0]) begin fails++; $display("FAIL rnd_route_id c=%0d: got %0d expected %0d", c, route_id, m_route[0]); end
      end
      tests++; if (busy !== (m_issue || m_route.size() != 0)) begin fails++; $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy, m_issue || m_route.size() != 0); end
      beat = mon_tvalid && mon_tready && mon_tlast;
      if (beat && m_route.size() != 0) void'(m_route.pop_front());
      if (exp_cv && cmd_tready) begin
        m_route.push_back(int'(m_cmds[0][27:24]));
        void'(m_cmds.pop_front());
        if (m_cmds.size() == 0) m_issue = 0;
      end
      if (win >= 0) begin
        logic [31:0] addr;
        logic [31:0] rem;
        logic [31:0] n;
        addr = a[win];
        rem  = s[win];
        while (rem != 0) begin
          n = (rem < 32'd4096) ? rem : 32'd4096;
          m_cmds.push_back(exp_word(addr, n, win));
          addr = addr + n;
          rem  = rem - n;
        end
        if (s[win] != 0) m_issue = 1;
        m_rr = (win + 1) % 2;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    idle_inputs();
    test_reset();
    test_chunks();
    test_round_robin();
    test_max_out();
    test_zero_size();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
